// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
//
// Stall/flush controller for a five-stage in-order pipeline with blocking
// instruction and data caches. The pipeline controls are pure combinational
// functions of the current hazard inputs. The miss state, the miss watchdog
// and the stall performance counter are registered.
//
// Build option:
//   STALL_PERF_CNT_EN - when defined, StallCycles counts cycles with StallF=1
//                       and saturates at all-ones. When undefined,
//                       StallCycles is tied to zero and no counter flops exist.
//
// Parameters:
//   TIMEOUT_CYCLES - miss watchdog threshold in cycles (1..65535)
//   CNT_W          - width of StallCycles
//
// Ports:
//   clk           in   sole clock
//   reset         in   asynchronous reset, active low
//   Ihit          in   instruction fetch satisfied this cycle
//   Dhit          in   data access satisfied this cycle
//   MemAccessM    in   memory stage holds a load/store
//   LoadUseD      in   load-use hazard detected in decode
//   BranchTakenD  in   taken-branch redirect resolved in decode
//   StallF/D      out  hold fetch/decode registers
//   FlushD/E      out  bubble into decode/execute registers
//   EnE/M/W       out  load enables for execute/memory/write-back registers
//   MissState     out  registered {Dmiss, Imiss}
//   MissTimeout   out  sticky watchdog flag
//   StallCycles   out  stall performance count
//
// state  | meaning
// -------+------------------------------------------
// RUN    | no cache miss outstanding
// IMISS  | instruction miss only
// DMISS  | data miss only
// IDMISS | instruction and data miss together
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Ihit,
    input  logic             Dhit,
    input  logic             MemAccessM,
    input  logic             LoadUseD,
    input  logic             BranchTakenD,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             EnE,
    output logic             EnM,
    output logic             EnW,
    output logic [1:0]       MissState,
    output logic             MissTimeout,
    output logic [CNT_W-1:0] StallCycles
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        IMISS  = 2'b01,
        DMISS  = 2'b10,
        IDMISS = 2'b11
    } miss_state_t;

    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES);

    logic        dmiss;
    logic        imiss;
    logic        stall_front;
    miss_state_t state;
    miss_state_t state_next;
    logic [15:0] watchdog;

    assign dmiss       = MemAccessM & ~Dhit;
    assign imiss       = ~Ihit;
    assign stall_front = imiss | LoadUseD;

    // A data miss freezes everything. A front-end stall holds F/D and
    // injects a bubble into E. A branch redirect is honoured only when
    // decode is not held, because a held decode re-evaluates next cycle.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        EnE    = 1'b1;
        EnM    = 1'b1;
        EnW    = 1'b1;
        if (dmiss) begin
            StallF = 1'b1;
            StallD = 1'b1;
            EnE    = 1'b0;
            EnM    = 1'b0;
            EnW    = 1'b0;
        end else if (stall_front) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else if (BranchTakenD) begin
            FlushD = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Every state can reach every other state in one cycle. The next state
    // is simply the current miss pair.
    always_comb begin
        state_next = miss_state_t'({dmiss, imiss});
    end

    always_comb begin
        MissState = state;
    end

    // The watchdog clears only on a fully clean cycle. A change of miss
    // type keeps accumulating, so one long IMISS->IDMISS->DMISS episode
    // still trips the flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            watchdog <= '0;
        end else if (!(dmiss | imiss)) begin
            watchdog <= '0;
        end else if (watchdog != WD_LIMIT) begin
            watchdog <= watchdog + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            MissTimeout <= 1'b0;
        end else if (watchdog == WD_LIMIT) begin
            MissTimeout <= 1'b1;
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (StallF && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign StallCycles = stall_cnt;
`else
    assign StallCycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//
// Directed bench for pipeline_stall_ctrl built with TIMEOUT_CYCLES=4 so the
// watchdog can be exercised quickly. Expected values come from a small
// behavioural model and are queued as stimulus is applied, then popped and
// checked once the DUT output is settled.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

    localparam int T_OUT = 4;
    localparam int CW    = 32;

    logic          clk;
    logic          reset;
    logic          Ihit;
    logic          Dhit;
    logic          MemAccessM;
    logic          LoadUseD;
    logic          BranchTakenD;
    logic          StallF;
    logic          StallD;
    logic          FlushD;
    logic          FlushE;
    logic          EnE;
    logic          EnM;
    logic          EnW;
    logic [1:0]    MissState;
    logic          MissTimeout;
    logic [CW-1:0] StallCycles;

    pipeline_stall_ctrl #(
        .TIMEOUT_CYCLES(T_OUT),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Ihit(Ihit),
        .Dhit(Dhit),
        .MemAccessM(MemAccessM),
        .LoadUseD(LoadUseD),
        .BranchTakenD(BranchTakenD),
        .StallF(StallF),
        .StallD(StallD),
        .FlushD(FlushD),
        .FlushE(FlushE),
        .EnE(EnE),
        .EnM(EnM),
        .EnW(EnW),
        .MissState(MissState),
        .MissTimeout(MissTimeout),
        .StallCycles(StallCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    string       tag_q[$];
    logic [63:0] exp_q[$];

    // model state
    logic [1:0]  m_state;
    int          m_wd;
    logic        m_to;
    logic [63:0] m_cnt;

    function automatic logic [6:0] comb_model(input logic ih, dh, ma, lu, bt);
        logic dm, fs, sf;
        dm = ma & ~dh;
        fs = (~ih | lu) & ~dm;
        sf = dm | fs;
        // {StallF, StallD, FlushD, FlushE, EnE, EnM, EnW}
        return {sf, sf, bt & ~sf, fs, ~dm, ~dm, ~dm};
    endfunction

    function automatic logic [6:0] comb_obs();
        return {StallF, StallD, FlushD, FlushE, EnE, EnM, EnW};
    endfunction

    task automatic sb_push(input string t, input logic [63:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input logic [63:0] obs);
        string       t;
        logic [63:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        n_cmp++;
        assert (obs === e)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", t, obs, e);
        end
    endtask

    task automatic check_regs(input string t);
        sb_push({t, ".MissState"}, 64'(m_state));
        sb_push({t, ".MissTimeout"}, 64'(m_to));
        sb_push({t, ".StallCycles"}, m_cnt);
        sb_check(64'(MissState));
        sb_check(64'(MissTimeout));
        sb_check(64'(StallCycles));
    endtask

    task automatic model_reset();
        m_state = 2'b00;
        m_wd    = 0;
        m_to    = 1'b0;
        m_cnt   = '0;
    endtask

    // One clock cycle: drive at the falling edge, check the combinational
    // outputs mid-cycle, then check registered state just after the rise.
    task automatic step(input string t, input logic ih, dh, ma, lu, bt);
        logic [6:0] ce;
        logic       dm, im;
        Ihit         = ih;
        Dhit         = dh;
        MemAccessM   = ma;
        LoadUseD     = lu;
        BranchTakenD = bt;
        ce = comb_model(ih, dh, ma, lu, bt);
        sb_push({t, ".comb"}, 64'(ce));
        #1;
        sb_check(64'(comb_obs()));
        dm = ma & ~dh;
        im = ~ih;
        m_to    = m_to | (m_wd == T_OUT);
        m_wd    = (dm | im) ? ((m_wd == T_OUT) ? m_wd : m_wd + 1) : 0;
        m_state = {dm, im};
`ifdef STALL_PERF_CNT_EN
        if (ce[6]) m_cnt = m_cnt + 64'd1;
`endif
        @(posedge clk);
        #1;
        check_regs(t);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string t);
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        check_regs(t);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset        = 1'b0;
        Ihit         = 1'b1;
        Dhit         = 1'b1;
        MemAccessM   = 1'b0;
        LoadUseD     = 1'b0;
        BranchTakenD = 1'b0;
        model_reset();

        // reset values; comb outputs keep following inputs while in reset
        #2;
        check_regs("rst");
        sb_push("rst.comb_idle", 64'(comb_model(1, 1, 0, 0, 0)));
        sb_check(64'(comb_obs()));
        Ihit = 1'b0;
        #1;
        sb_push("rst.comb_imiss", 64'(comb_model(0, 1, 0, 0, 0)));
        sb_check(64'(comb_obs()));
        @(posedge clk);
        #1;
        check_regs("rst_clk");
        @(negedge clk);
        reset = 1'b1;

        step("idle", 1, 1, 0, 0, 0);

        // data miss for three cycles then data hit
        step("dmiss1", 1, 0, 1, 0, 0);
        step("dmiss2", 1, 0, 1, 0, 0);
        step("dmiss3", 1, 0, 1, 0, 0);
        step("dhit",   1, 1, 1, 0, 0);

        // instruction miss, no memory access
        step("imiss",  0, 0, 0, 0, 0);
        step("ihit",   1, 0, 0, 0, 0);

        // branch ignored while decode stalled, honoured the next cycle
        step("br_imiss", 0, 1, 0, 0, 1);
        step("br_ok",    1, 1, 0, 0, 1);

        // load-use priority over branch, data miss over everything
        step("lu_br",    1, 1, 0, 1, 1);
        step("dm_lu_br", 0, 0, 1, 1, 1);
        step("clean",    1, 1, 1, 0, 0);

        // miss type changes keep the watchdog counting
        step("chain_im1", 0, 1, 0, 0, 0);
        step("chain_id1", 0, 0, 1, 0, 0);
        step("chain_dm1", 1, 0, 1, 0, 0);
        step("chain_id2", 0, 0, 1, 0, 0);
        step("chain_im2", 0, 1, 1, 0, 0);
        step("chain_clr", 1, 1, 0, 0, 0);
        async_reset("chain_rst");

        // pure data miss held five cycles
        for (int i = 0; i < 5; i++) begin
            step($sformatf("wd_dm%0d", i), 1, 0, 1, 0, 0);
        end
        step("wd_dhit", 1, 1, 1, 0, 0);
        step("wd_hold", 1, 1, 0, 0, 0);
        async_reset("wd_rst");

        // seven stall cycles interleaved with three clean cycles
        step("pc_s1", 0, 1, 0, 0, 0);
        step("pc_s2", 1, 1, 0, 1, 0);
        step("pc_c1", 1, 1, 0, 0, 1);
        step("pc_s3", 1, 0, 1, 0, 0);
        step("pc_s4", 0, 0, 1, 0, 0);
        step("pc_c2", 1, 1, 0, 0, 0);
        step("pc_s5", 1, 1, 0, 1, 1);
        step("pc_s6", 0, 1, 0, 1, 0);
        step("pc_c3", 1, 1, 1, 0, 0);
        step("pc_s7", 1, 0, 1, 0, 0);
`ifdef STALL_PERF_CNT_EN
        sb_push("pc_total", 64'd7);
`else
        sb_push("pc_total", 64'd0);
`endif
        sb_check(64'(StallCycles));

        // async reset while in IDMISS, then resume from RUN
        step("id_enter", 0, 0, 1, 0, 0);
        async_reset("id_rst");
        step("id_resume", 0, 0, 1, 0, 0);
        step("id_exit",   1, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no end of run, expected completion");
        $fatal(1, "bench time limit reached");
    end

endmodule
